aes_round_ctrl: RTL and testbench

Iterative AES-128 encryption controller that sequences the single-round datapath (`rounds`) ten times per block: initial AddRoundKey, nine full rounds and one final round without MixColumns. It holds the working state and round key in registers, drives the round counter into the key schedule, and presents a valid/ready streaming interface on both input and output. The block sits between the block-cipher front end (plaintext/key source) and the ciphertext sink, one block in flight at a time.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_last_round.sv | 15 +
 rtl/rounds.sv | 46 ++++
 rtl/shiftrow.sv | 16 +
 rtl/subbytes.sv | 14 +
 rtl/aes_round_ctrl.sv | 102 ++++++++++
 tb/tb_aes_round_ctrl.sv | 216 +++++++++++++++++++++
 7 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, controller state type and byte-level helpers.
// Byte order: byte 0 of every 128-bit block sits in [127:120]; bytes fill the state column by column.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {b, 3'b000};
    return SBOX_TBL[11'd2047 - idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_last_round.sv
// Final AES round: SubBytes and ShiftRows without MixColumns, then the round-10 key.
module aes_last_round (
  input  logic [127:0] data,
  input  logic [127:0] rkey,
  output logic [127:0] out
);

  logic [127:0] sb, sr;

  subbytes u_sb (.data(data), .sb(sb));
  shiftrow u_sr (.data(sb),   .sr(sr));

  assign out = sr ^ rkey;

endmodule

// File: rtl/rounds.sv
// One full AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey) plus the
// key-schedule step that derives round key `roundcount` from the previous one.
module rounds
  import aes_pkg::*;
(
  input  logic [3:0]   roundcount,
  input  logic [127:0] data,
  input  logic [127:0] keyin,
  output logic [127:0] rndout,
  output logic [127:0] keyout
);

  logic [127:0] sb, sr, mc;
  logic [31:0]  tmp, k0, k1, k2, k3;
  logic [7:0]   a0, a1, a2, a3;

  subbytes u_sb (.data(data), .sb(sb));
  shiftrow u_sr (.data(sb),   .sr(sr));

  always_comb begin
    mc = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = sr[127 - 32*c -: 32];
      mc[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
  end

  // RotWord + SubWord of the last key word, then the round constant.
  assign tmp = {sbox(keyin[23:16]), sbox(keyin[15:8]), sbox(keyin[7:0]), sbox(keyin[31:24])}
               ^ {rcon(roundcount), 24'h000000};
  assign k0 = keyin[127:96] ^ tmp;
  assign k1 = keyin[95:64]  ^ k0;
  assign k2 = keyin[63:32]  ^ k1;
  assign k3 = keyin[31:0]   ^ k2;

  assign keyout = {k0, k1, k2, k3};
  assign rndout = mc ^ keyout;

endmodule

// File: rtl/shiftrow.sv
// ShiftRows: row r of the column-major state rotates left by r bytes.
module shiftrow (
  input  logic [127:0] data,
  output logic [127:0] sr
);

  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127 - 8*(4*c + r) -: 8] = data[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
  end

endmodule

// File: rtl/subbytes.sv
// SubBytes: S-box applied independently to all sixteen state bytes.
module subbytes
  import aes_pkg::*;
(
  input  logic [127:0] data,
  output logic [127:0] sb
);

  always_comb begin
    sb = '0;
    for (int i = 0; i < 16; i++) sb[8*i +: 8] = sbox(data[8*i +: 8]);
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: one block in flight, rounds 1..9 through
// the shared round datapath, round 10 through the last-round unit, valid/ready on both sides.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] plaintext,
  input  logic [AES_BLK_W-1:0] key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] ciphertext,
  output logic                 busy,
  output logic [3:0]           round_idx
);

  localparam logic [3:0] RC_LAST = 4'(NR);

  aes_state_e           state, state_nxt;
  logic [3:0]           rc;
  logic [AES_BLK_W-1:0] st_reg, key_reg, rndout, keyout, last_out;

  rounds u_rounds (
    .roundcount(rc),
    .data      (st_reg),
    .keyin     (key_reg),
    .rndout    (rndout),
    .keyout    (keyout)
  );

  // At rc == 10 the schedule output is already the round-10 key.
  aes_last_round u_last (
    .data(st_reg),
    .rkey(keyout),
    .out (last_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)       state_nxt = ROUND;
      ROUND:   if (rc == RC_LAST)  state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
    if (rc > RC_LAST) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc         <= '0;
      st_reg     <= '0;
      key_reg    <= '0;
      ciphertext <= '0;
      out_valid  <= 1'b0;
    end else if (rc > RC_LAST) begin
      rc        <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st_reg  <= plaintext ^ key;
            key_reg <= key;
            rc      <= 4'd1;
          end
        end
        ROUND: begin
          if (rc < RC_LAST) begin
            st_reg  <= rndout;
            key_reg <= keyout;
            rc      <= rc + 4'd1;
          end else begin
            ciphertext <= last_out;
            out_valid  <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rc        <= '0;
          end
        end
        default: rc <= '0;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign round_idx = rc;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: FIPS-197 vectors, latency, backpressure,
// back-to-back throughput, mid-block reset and ignored input while busy.
module tb_aes_round_ctrl;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] ciphertext;
  logic [3:0]   round_idx;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int out_cnt = 0;

  aes_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plaintext (plaintext),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ciphertext(ciphertext),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready)   acc_cnt <= acc_cnt + 1;
    if (out_valid && out_ready) out_cnt <= out_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at the negedge before the accepting edge; returns at the negedge where out_valid is first seen.
  task automatic wait_result(input string tag, input logic [127:0] exp, input bit pulse);
    int cyc;
    cyc = 0;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    while (!out_valid && cyc < 40) begin
      chk($sformatf("%s_ridx%0d", tag, cyc + 1), 128'(round_idx), 128'(cyc + 1));
      if (pulse) begin
        plaintext = PT_B;
        key       = KEY_B;
        in_valid  = (cyc == 2 || cyc == 3);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, 128'(cyc), 128'(10));
    chk({tag, "_ct"}, ciphertext, exp);
    chk({tag, "_ridx_done"}, 128'(round_idx), 128'(10));
  endtask

  initial begin
    logic [127:0] pts [3];
    logic [127:0] keys[3];
    logic [127:0] cts [3];
    bit ok;
    int nin, nout, last, n;

    pts  = '{PT_B, PT_C, 128'h0};
    keys = '{KEY_B, KEY_C, 128'h0};
    cts  = '{CT_B, CT_C, CT_Z};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_round_idx", 128'(round_idx), 128'(0));
    chk("rst_ct", ciphertext, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'(1));

    out_ready = 1'b1;
    plaintext = PT_B;
    key       = KEY_B;
    in_valid  = 1'b1;
    wait_result("appB", CT_B, 1'b0);
    @(negedge clk);
    chk("appB_xfer_ovalid", 128'(out_valid), 128'(0));
    chk("appB_xfer_in_ready", 128'(in_ready), 128'(1));
    chk("appB_xfer_busy", 128'(busy), 128'(0));
    chk("appB_xfer_ridx", 128'(round_idx), 128'(0));
    chk("appB_ct_retained", ciphertext, CT_B);

    out_ready = 1'b0;
    plaintext = PT_C;
    key       = KEY_C;
    in_valid  = 1'b1;
    wait_result("appC", CT_C, 1'b0);
    plaintext = PT_B;
    key       = KEY_B;
    in_valid  = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && ciphertext === CT_C && in_ready === 1'b0 && round_idx === 4'd10))
        ok = 1'b0;
    end
    chk("bp_stable", 128'(ok), 128'(1));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ovalid", 128'(out_valid), 128'(0));
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));
    wait_result("bp_second", CT_B, 1'b0);
    @(negedge clk);

    nin  = 0;
    nout = 0;
    last = 0;
    for (int cyc = 0; cyc < 60 && nout < 3; cyc++) begin
      if (out_valid) begin
        chk($sformatf("b2b_ct%0d", nout), ciphertext, cts[nout]);
        if (nout > 0) chk($sformatf("b2b_period%0d", nout), 128'(cyc - last), 128'(12));
        last = cyc;
        nout++;
      end
      if (in_ready) begin
        if (nin < 3) begin
          plaintext = pts[nin];
          key       = keys[nin];
          in_valid  = 1'b1;
          nin++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_count", 128'(nout), 128'(3));
    ok = 1'b1;
    repeat (14) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("b2b_no_extra", 128'(ok), 128'(1));

    plaintext = PT_B;
    key       = KEY_B;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (round_idx !== 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_rc5", 128'(round_idx), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ovalid", 128'(out_valid), 128'(0));
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_in_ready", 128'(in_ready), 128'(1));
    chk("rst_mid_ridx", 128'(round_idx), 128'(0));
    chk("rst_mid_ct", ciphertext, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("rst_no_stale", 128'(ok), 128'(1));
    plaintext = PT_B;
    key       = KEY_B;
    in_valid  = 1'b1;
    wait_result("post_rst", CT_B, 1'b0);
    @(negedge clk);

    plaintext = PT_C;
    key       = KEY_C;
    in_valid  = 1'b1;
    wait_result("pulse", CT_C, 1'b1);
    ok = 1'b1;
    repeat (14) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("pulse_no_extra", 128'(ok), 128'(1));

    chk("blocks_in", 128'(acc_cnt), 128'(9));
    chk("blocks_out", 128'(out_cnt), 128'(8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
